serial_adder_hs: RTL and testbench

- Parametrised, multi-cycle successor to the single-bit full adder cell.
- Adds two WIDTH-bit operands with carry-in by iterating a BITS_PER_CYCLE-wide full-adder slice over the operands, LSB slice first.
- Valid/ready handshakes on input and output.
- Sits between operand producers and result consumers where an area-cheap adder is preferred over a full-width ripple adder.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_adder_hs_full_adder_bit.sv | 17 +
 rtl/serial_adder_hs.sv | 156 +++++++++++++++
 tb/tb_serial_adder_hs.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the handshaked serial adder.
// Holds the controller state encoding and the step-counter sizing rule.

package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width: enough bits to count WIDTH/BITS_PER_CYCLE slices,
    // never less than one bit so a single-step build still has a counter.
    function automatic int counter_width(input int width, input int bits_per_cycle);
        int steps;
        steps = width / bits_per_cycle;
        if (steps <= 2) begin
            return 1;
        end
        return $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_hs_full_adder_bit.sv
// Single-bit full adder cell, chained by the serial adder to form one slice.

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational sum and carry of three input bits.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_adder_hs.sv
// Multi-cycle adder with valid/ready handshakes on both sides.
// Operands are consumed BITS_PER_CYCLE bits per clock, LSB slice first,
// through a chain of full_adder_bit cells; the result is presented until
// the consumer takes it.
// Optional build macro: SERIAL_ADDER_SUB_EN enables the subtract request
// on port sub (a - b modulo 2^WIDTH, cout=1 meaning no borrow).

module serial_adder_hs
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = counter_width(WIDTH, BITS_PER_CYCLE);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_slice
            $error("serial_adder_hs: BITS_PER_CYCLE must divide WIDTH");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_adder_hs: WIDTH must be at least 2");
        end
    endgenerate

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]        opa;
    logic [WIDTH-1:0]        opb;
    logic [WIDTH-1:0]        res;
    logic [WIDTH-1:0]        res_next;
    logic                    carry;
    logic [CW-1:0]           cnt;
    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic [BITS_PER_CYCLE:0]   chain;
    logic [WIDTH-1:0]        opb_load;
    logic                    carry_load;
    logic                    accept;
    logic                    last_step;

    assign accept    = in_valid && in_ready;
    assign last_step = (state == RUN) && (cnt == LAST);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1: invert B and force the carry-in at load time.
    always_comb begin
        opb_load   = sub ? ~b : b;
        carry_load = sub ? 1'b1 : cin;
    end
`else
    // Add-only build: operands load untouched, sub is kept only on the port.
    always_comb begin
        opb_load   = b;
        carry_load = cin;
    end

    logic unused_sub;
    assign unused_sub = sub;
`endif

    // The slice: BITS_PER_CYCLE full adders rippling from the running carry.
    assign chain[0] = carry;

    generate
        for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_slice
            full_adder_bit u_fa (
                .a    (opa[g]),
                .b    (opb[g]),
                .cin  (chain[g]),
                .sum  (slice_sum[g]),
                .cout (chain[g+1])
            );
        end
    endgenerate

    // New slice bits enter the result register from the MSB side, so after
    // STEPS shifts the first slice computed has landed in the LSBs.
    always_comb begin
        res_next = (res >> BITS_PER_CYCLE)
                 | (WIDTH'(slice_sum) << (WIDTH - BITS_PER_CYCLE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, run STEPS slices, wait for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)    state_next = RUN;
            RUN:  if (last_step) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state; no acceptance while DONE.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // Datapath: load operands on acceptance, shift one slice per RUN cycle,
    // publish sum/cout only on the edge that completes the final slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= opb_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> BITS_PER_CYCLE;
            opb   <= opb >> BITS_PER_CYCLE;
            res   <= res_next;
            carry <= chain[BITS_PER_CYCLE];
            cnt   <= cnt + CW'(1);
            if (last_step) begin
                sum  <= res_next;
                cout <= chain[BITS_PER_CYCLE];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_hs.sv
// Bench for serial_adder_hs: an 8-bit/1-bit-per-cycle instance and a
// 16-bit/4-bits-per-cycle instance, checked every cycle against a
// transaction-level model and against hand-computed literal results.

module tb_serial_adder_hs;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit          SUB_ON  = 1'b1;
    localparam logic [15:0] SUB_EXP = 16'hFFFE;
`else
    localparam bit          SUB_ON  = 1'b0;
    localparam logic [15:0] SUB_EXP = 16'h000C;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       iv0, ir0, cin0, sub0, ov0, or0, cout0, busy0;
    logic [7:0] a0, b0, sum0;

    logic        iv1, ir1, cin1, sub1, ov1, or1, cout1, busy1;
    logic [15:0] a1, b1, sum1;

    serial_adder_hs #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .out_valid(ov0), .out_ready(or0),
        .sum(sum0), .cout(cout0), .busy(busy0)
    );

    serial_adder_hs #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(ov1), .out_ready(or1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Transaction-level view: is a job held, how many cycles since it was
    // accepted, its arithmetic result, and the last published sum/cout.
    typedef struct {
        bit          busy;
        int          cyc;
        logic [31:0] res;
        logic        rc;
        logic [31:0] hsum;
        logic        hcout;
    } model_t;

    model_t m0 = '{busy:1'b0, cyc:0, res:32'h0, rc:1'b0, hsum:32'h0, hcout:1'b0};
    model_t m1 = '{busy:1'b0, cyc:0, res:32'h0, rc:1'b0, hsum:32'h0, hcout:1'b0};

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timed out", name);
    endtask

    function automatic model_t stepModel(input model_t m, input int steps, input int width,
                                         input logic r, input logic iv,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub, input logic ordy);
        model_t     n;
        logic [32:0] mask;
        logic [32:0] full;
        logic        eff_sub;
        n       = m;
        mask    = (33'd1 << width) - 33'd1;
        eff_sub = sub & SUB_ON;
        if (r) begin
            n.busy  = 1'b0;
            n.cyc   = 0;
            n.hsum  = 32'h0;
            n.hcout = 1'b0;
        end else if (!m.busy) begin
            if (iv) begin
                if (eff_sub)
                    full = ({1'b0, a} & mask) + ((~{1'b0, b}) & mask) + 33'd1;
                else
                    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 33'(cin);
                n.busy = 1'b1;
                n.cyc  = 0;
                n.res  = 32'(full & mask);
                n.rc   = full[width];
            end
        end else if (m.cyc >= steps) begin
            if (ordy) n.busy = 1'b0;
        end else begin
            n.cyc = m.cyc + 1;
            if (n.cyc == steps) begin
                n.hsum  = m.res;
                n.hcout = m.rc;
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input model_t m, input int steps,
                               input logic ir, input logic ov, input logic bz,
                               input logic [31:0] s, input logic c);
        cmp({tag, "_in_ready"},  32'(ir), 32'(!m.busy));
        cmp({tag, "_out_valid"}, 32'(ov), 32'(m.busy && (m.cyc >= steps)));
        cmp({tag, "_busy"},      32'(bz), 32'(m.busy));
        cmp({tag, "_sum"},       s,       m.hsum);
        cmp({tag, "_cout"},      32'(c),  32'(m.hcout));
    endtask

    // Compare on the falling edge, then advance the model with the inputs
    // that the coming rising edge will see.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("d0", m0, 8, ir0, ov0, busy0, 32'(sum0), cout0);
            checkOutput("d1", m1, 4, ir1, ov1, busy1, 32'(sum1), cout1);
        end
        m0 = stepModel(m0, 8, 8,  rst, iv0, 32'(a0), 32'(b0), cin0, sub0, or0);
        m1 = stepModel(m1, 4, 16, rst, iv1, 32'(a1), 32'(b1), cin1, sub1, or1);
    end

    task automatic applyStimulus(input string name, input int sel,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input int hold,
                                 input logic [15:0] exp_sum, input logic exp_cout);
        int          steps;
        int          lat;
        int          low;
        bit          got;
        bit          done;
        logic        ir;
        logic        ov;
        logic [15:0] gs;
        logic        gc;
        steps = (sel == 0) ? 8 : 4;
        lat   = -1;
        low   = 0;
        got   = 1'b0;
        done  = 1'b0;
        gs    = 16'h0;
        gc    = 1'b0;
        @(posedge clk); #1;
        if (sel == 0) begin
            a0 = a[7:0]; b0 = b[7:0]; cin0 = cin; sub0 = sub; iv0 = 1'b1; or0 = (hold == 0);
        end else begin
            a1 = a; b1 = b; cin1 = cin; sub1 = sub; iv1 = 1'b1; or1 = (hold == 0);
        end
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = (sel == 0) ? ir0 : ir1;
            @(posedge clk); #1;
        end
        if (sel == 0) iv0 = 1'b0; else iv1 = 1'b0;
        if (!got) begin
            timeoutFail({name, "_accept"});
            return;
        end
        for (int k = 0; k < 60 && !done; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            ir = (sel == 0) ? ir0 : ir1;
            ov = (sel == 0) ? ov0 : ov1;
            if (ir) done = 1'b1;
            else    low++;
            if (ov && lat < 0) begin
                lat = k;
                gs  = (sel == 0) ? {8'h00, sum0} : sum1;
                gc  = (sel == 0) ? cout0 : cout1;
            end
            if (lat >= 0 && k == lat + hold) begin
                if (sel == 0) or0 = 1'b1; else or1 = 1'b1;
            end
        end
        if (!done) timeoutFail({name, "_release"});
        cmp({name, "_latency"},   32'(lat), 32'(steps));
        cmp({name, "_ready_low"}, 32'(low), 32'(steps + 1 + hold));
        cmp({name, "_sum"},       32'(gs),  32'(exp_sum));
        cmp({name, "_cout"},      32'(gc),  32'(exp_cout));
    endtask

    task automatic resetMidRun();
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        a0 = 8'h55; b0 = 8'h22; cin0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1; or0 = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = ir0;
            @(posedge clk); #1;
        end
        iv0 = 1'b0;
        if (!got) begin
            timeoutFail("rst_accept");
            return;
        end
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cmp("rst_in_ready", 32'(ir0), 32'h1);
        for (int k = 0; k < 12; k++) begin
            cmp("rst_abort_out_valid", 32'(ov0), 32'h0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        iv0 = 1'b0; a0 = 8'h0;  b0 = 8'h0;  cin0 = 1'b0; sub0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; a1 = 16'h0; b1 = 16'h0; cin1 = 1'b0; sub1 = 1'b0; or1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_en = 1'b1;
        $display("[TB] reset released");

        cmp("reset_in_ready",  32'(ir0),   32'h1);
        cmp("reset_out_valid", 32'(ov0),   32'h0);
        cmp("reset_busy",      32'(busy0), 32'h0);
        cmp("reset_sum",       32'(sum0),  32'h0);
        cmp("reset_cout",      32'(cout0), 32'h0);

        applyStimulus("add_0f_01",   0, 16'h000F, 16'h0001, 1'b0, 1'b0, 0, 16'h0010, 1'b0);
        applyStimulus("wrap_ff_01",  0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1);
        applyStimulus("ff_ff_cin",   0, 16'h00FF, 16'h00FF, 1'b1, 1'b0, 0, 16'h00FF, 1'b1);
        applyStimulus("hold_80_80",  0, 16'h0080, 16'h0080, 1'b0, 1'b0, 5, 16'h0000, 1'b1);
        resetMidRun();
        applyStimulus("after_rst",   0, 16'h0012, 16'h0034, 1'b0, 1'b0, 0, 16'h0046, 1'b0);
        applyStimulus("w16_sub",     1, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, SUB_EXP,  1'b0);
        applyStimulus("w16_add",     1, 16'h0005, 16'h0007, 1'b0, 1'b0, 0, 16'h000C, 1'b0);
        applyStimulus("w16_wrap",    1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 2, 16'h0001, 1'b1);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
